// File: rtl/pipe_stage_regs.sv
// Post-decode pipeline register bank: DA (decode->ALU), AC (ALU->cache), CW (cache->writeback).
// Optional `PIPE_STALL_EN adds a stall input that freezes DA/AC and bubbles CW.
module pipe_stage_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OPC_WIDTH  = 7,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef PIPE_STALL_EN
  input  logic                  stall,
`endif
  input  logic [DATA_WIDTH-1:0] D_dataA,
  input  logic [DATA_WIDTH-1:0] D_dataB,
  input  logic [OPC_WIDTH-1:0]  D_opcode,
  input  logic [REG_WIDTH-1:0]  D_regDst,
  input  logic [1:0]            D_DC_rd_wr,
  input  logic                  D_DC_we,
  input  logic                  D_MuxD,
  input  logic                  D_RF_wrd,
  input  logic                  D_kill,
  input  logic [ADDR_WIDTH-1:0] D_PC,
  input  logic [ADDR_WIDTH-1:0] D_BranchOffset,
  output logic [DATA_WIDTH-1:0] A_dataA,
  output logic [DATA_WIDTH-1:0] A_dataB,
  output logic [OPC_WIDTH-1:0]  A_opcode,
  output logic [REG_WIDTH-1:0]  A_regDst,
  output logic [1:0]            A_DC_rd_wr,
  output logic                  A_DC_we,
  output logic                  A_MuxD,
  output logic                  A_RF_wrd,
  output logic                  A_kill,
  output logic [ADDR_WIDTH-1:0] A_PC,
  output logic [ADDR_WIDTH-1:0] A_BranchOffset,
  input  logic [DATA_WIDTH-1:0] A_w,
  input  logic [REG_WIDTH-1:0]  A_regDst_i,
  input  logic [1:0]            A_DC_rd_wr_i,
  input  logic                  A_DC_we_i,
  input  logic                  A_MuxD_i,
  input  logic                  A_RF_wrd_i,
  output logic [DATA_WIDTH-1:0] C_w,
  output logic [REG_WIDTH-1:0]  C_regDst,
  output logic [1:0]            C_DC_rd_wr,
  output logic                  C_DC_we,
  output logic                  C_MuxD,
  output logic                  C_RF_wrd,
  input  logic [DATA_WIDTH-1:0] C_dataD,
  input  logic [DATA_WIDTH-1:0] C_w_i,
  input  logic [REG_WIDTH-1:0]  C_regDst_i,
  input  logic                  C_MuxD_i,
  input  logic                  C_RF_wrd_i,
  output logic [DATA_WIDTH-1:0] W_dataD,
  output logic [DATA_WIDTH-1:0] W_w,
  output logic [REG_WIDTH-1:0]  W_regDst,
  output logic                  W_MuxD,
  output logic                  W_RF_wrd
);

  logic w_stall;
`ifdef PIPE_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] r_a_dataA, r_a_dataB;
  logic [OPC_WIDTH-1:0]  r_a_opcode;
  logic [REG_WIDTH-1:0]  r_a_regDst;
  logic [1:0]            r_a_DC_rd_wr;
  logic                  r_a_DC_we, r_a_MuxD, r_a_RF_wrd, r_a_kill;
  logic [ADDR_WIDTH-1:0] r_a_PC, r_a_BranchOffset;

  logic [DATA_WIDTH-1:0] r_c_w;
  logic [REG_WIDTH-1:0]  r_c_regDst;
  logic [1:0]            r_c_DC_rd_wr;
  logic                  r_c_DC_we, r_c_MuxD, r_c_RF_wrd;

  logic [DATA_WIDTH-1:0] r_w_dataD, r_w_w;
  logic [REG_WIDTH-1:0]  r_w_regDst;
  logic                  r_w_MuxD, r_w_RF_wrd;

  // DA stage: decode -> ALU; reset leaves a killed bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_dataA        <= '0;
      r_a_dataB        <= '0;
      r_a_opcode       <= '0;
      r_a_regDst       <= '0;
      r_a_DC_rd_wr     <= '0;
      r_a_DC_we        <= 1'b0;
      r_a_MuxD         <= 1'b0;
      r_a_RF_wrd       <= 1'b0;
      r_a_kill         <= 1'b1;
      r_a_PC           <= '0;
      r_a_BranchOffset <= '0;
    end else if (!w_stall) begin
      r_a_dataA        <= D_dataA;
      r_a_dataB        <= D_dataB;
      r_a_opcode       <= D_opcode;
      r_a_regDst       <= D_regDst;
      r_a_DC_rd_wr     <= D_DC_rd_wr;
      r_a_DC_we        <= D_DC_we;
      r_a_MuxD         <= D_MuxD;
      r_a_RF_wrd       <= D_RF_wrd;
      r_a_kill         <= D_kill;
      r_a_PC           <= D_PC;
      r_a_BranchOffset <= D_BranchOffset;
    end
  end

  // AC stage: ALU -> cache
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_w        <= '0;
      r_c_regDst   <= '0;
      r_c_DC_rd_wr <= '0;
      r_c_DC_we    <= 1'b0;
      r_c_MuxD     <= 1'b0;
      r_c_RF_wrd   <= 1'b0;
    end else if (!w_stall) begin
      r_c_w        <= A_w;
      r_c_regDst   <= A_regDst_i;
      r_c_DC_rd_wr <= A_DC_rd_wr_i;
      r_c_DC_we    <= A_DC_we_i;
      r_c_MuxD     <= A_MuxD_i;
      r_c_RF_wrd   <= A_RF_wrd_i;
    end
  end

  // CW stage: cache -> writeback; a stall (cache miss) turns it into a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w_dataD  <= '0;
      r_w_w      <= '0;
      r_w_regDst <= '0;
      r_w_MuxD   <= 1'b0;
      r_w_RF_wrd <= 1'b0;
    end else begin
      r_w_dataD  <= C_dataD;
      r_w_w      <= C_w_i;
      r_w_regDst <= C_regDst_i;
      r_w_MuxD   <= C_MuxD_i & ~w_stall;
      r_w_RF_wrd <= C_RF_wrd_i & ~w_stall;
    end
  end

  assign A_dataA        = r_a_dataA;
  assign A_dataB        = r_a_dataB;
  assign A_opcode       = r_a_opcode;
  assign A_regDst       = r_a_regDst;
  assign A_DC_rd_wr     = r_a_DC_rd_wr;
  assign A_DC_we        = r_a_DC_we;
  assign A_MuxD         = r_a_MuxD;
  assign A_RF_wrd       = r_a_RF_wrd;
  assign A_kill         = r_a_kill;
  assign A_PC           = r_a_PC;
  assign A_BranchOffset = r_a_BranchOffset;

  assign C_w            = r_c_w;
  assign C_regDst       = r_c_regDst;
  assign C_DC_rd_wr     = r_c_DC_rd_wr;
  assign C_DC_we        = r_c_DC_we;
  assign C_MuxD         = r_c_MuxD;
  assign C_RF_wrd       = r_c_RF_wrd;

  assign W_dataD        = r_w_dataD;
  assign W_w            = r_w_w;
  assign W_regDst       = r_w_regDst;
  assign W_MuxD         = r_w_MuxD;
  assign W_RF_wrd       = r_w_RF_wrd;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboard bench for pipe_stage_regs: stimulus pushes expected group contents, a negedge monitor compares.
module tb_pipe_stage_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall;
  logic [31:0] D_dataA, D_dataB, D_PC, D_BranchOffset;
  logic [6:0]  D_opcode;
  logic [4:0]  D_regDst;
  logic [1:0]  D_DC_rd_wr;
  logic        D_DC_we, D_MuxD, D_RF_wrd, D_kill;
  logic [31:0] A_dataA, A_dataB, A_PC, A_BranchOffset;
  logic [6:0]  A_opcode;
  logic [4:0]  A_regDst;
  logic [1:0]  A_DC_rd_wr;
  logic        A_DC_we, A_MuxD, A_RF_wrd, A_kill;
  logic [31:0] A_w;
  logic [4:0]  A_regDst_i;
  logic [1:0]  A_DC_rd_wr_i;
  logic        A_DC_we_i, A_MuxD_i, A_RF_wrd_i;
  logic [31:0] C_w;
  logic [4:0]  C_regDst;
  logic [1:0]  C_DC_rd_wr;
  logic        C_DC_we, C_MuxD, C_RF_wrd;
  logic [31:0] C_dataD, C_w_i;
  logic [4:0]  C_regDst_i;
  logic        C_MuxD_i, C_RF_wrd_i;
  logic [31:0] W_dataD, W_w;
  logic [4:0]  W_regDst;
  logic        W_MuxD, W_RF_wrd;

  pipe_stage_regs dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PIPE_STALL_EN
    .stall(stall),
`endif
    .D_dataA(D_dataA), .D_dataB(D_dataB), .D_opcode(D_opcode), .D_regDst(D_regDst),
    .D_DC_rd_wr(D_DC_rd_wr), .D_DC_we(D_DC_we), .D_MuxD(D_MuxD), .D_RF_wrd(D_RF_wrd),
    .D_kill(D_kill), .D_PC(D_PC), .D_BranchOffset(D_BranchOffset),
    .A_dataA(A_dataA), .A_dataB(A_dataB), .A_opcode(A_opcode), .A_regDst(A_regDst),
    .A_DC_rd_wr(A_DC_rd_wr), .A_DC_we(A_DC_we), .A_MuxD(A_MuxD), .A_RF_wrd(A_RF_wrd),
    .A_kill(A_kill), .A_PC(A_PC), .A_BranchOffset(A_BranchOffset),
    .A_w(A_w), .A_regDst_i(A_regDst_i), .A_DC_rd_wr_i(A_DC_rd_wr_i), .A_DC_we_i(A_DC_we_i),
    .A_MuxD_i(A_MuxD_i), .A_RF_wrd_i(A_RF_wrd_i),
    .C_w(C_w), .C_regDst(C_regDst), .C_DC_rd_wr(C_DC_rd_wr), .C_DC_we(C_DC_we),
    .C_MuxD(C_MuxD), .C_RF_wrd(C_RF_wrd),
    .C_dataD(C_dataD), .C_w_i(C_w_i), .C_regDst_i(C_regDst_i), .C_MuxD_i(C_MuxD_i),
    .C_RF_wrd_i(C_RF_wrd_i),
    .W_dataD(W_dataD), .W_w(W_w), .W_regDst(W_regDst), .W_MuxD(W_MuxD), .W_RF_wrd(W_RF_wrd)
  );

  typedef struct packed {
    logic [145:0] da;
    logic [41:0]  ac;
    logic [70:0]  cw;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [145:0] DA_RST = {32'h0, 32'h0, 7'h0, 5'h0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};

  function automatic logic [145:0] da_in();
    return {D_dataA, D_dataB, D_opcode, D_regDst, D_DC_rd_wr, D_DC_we, D_MuxD, D_RF_wrd,
            D_kill, D_PC, D_BranchOffset};
  endfunction

  task automatic check(input string name, input logic [145:0] got, input logic [145:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every negedge with a pending expectation compares all three groups
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("DA", {A_dataA, A_dataB, A_opcode, A_regDst, A_DC_rd_wr, A_DC_we, A_MuxD, A_RF_wrd,
                   A_kill, A_PC, A_BranchOffset}, e.da);
      check("AC", 146'({C_w, C_regDst, C_DC_rd_wr, C_DC_we, C_MuxD, C_RF_wrd}), 146'(e.ac));
      check("CW", 146'({W_dataD, W_w, W_regDst, W_MuxD, W_RF_wrd}), 146'(e.cw));
    end
  end

  // One clock edge with the currently driven inputs; expected state follows the register behaviour
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model.da = DA_RST;
      model.ac = '0;
      model.cw = '0;
    end else begin
      if (!stall) begin
        model.da = da_in();
        model.ac = {A_w, A_regDst_i, A_DC_rd_wr_i, A_DC_we_i, A_MuxD_i, A_RF_wrd_i};
      end
      model.cw = {C_dataD, C_w_i, C_regDst_i, C_MuxD_i & ~stall, C_RF_wrd_i & ~stall};
    end
    exp_q.push_back(model);
    #1;
  endtask

  task automatic set_all(input logic [31:0] p);
    D_dataA = p; D_dataB = ~p; D_opcode = p[6:0]; D_regDst = p[12:8];
    D_DC_rd_wr = p[1:0]; D_DC_we = p[2]; D_MuxD = p[3]; D_RF_wrd = p[4]; D_kill = p[5];
    D_PC = p ^ 32'h0F0F_0F0F; D_BranchOffset = {p[15:0], p[31:16]};
    A_w = p + 32'd1; A_regDst_i = p[20:16]; A_DC_rd_wr_i = p[9:8]; A_DC_we_i = p[10];
    A_MuxD_i = p[11]; A_RF_wrd_i = p[12];
    C_dataD = ~p + 32'd3; C_w_i = p ^ 32'hFFFF_0000; C_regDst_i = p[28:24];
    C_MuxD_i = p[13]; C_RF_wrd_i = p[14];
  endtask

  initial begin
    logic [31:0] pats [6];
    pats = '{32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0000, 32'h8000_0001, 32'h1234_5678};
    model = '0;
    stall = 1'b0;
    rst_n = 1'b0;
    // Reset with every input busy, including write enables
    set_all(32'hFFFF_FFFF);
    D_kill = 1'b0;
    step();
    rst_n = 1'b1;

    set_all(32'h0);
    D_dataA = 32'hDEADBEEF; D_opcode = 7'h15; D_regDst = 5'd3; D_PC = 32'h40; D_kill = 1'b0;
    step();

    // Flow of one instruction across three edges
    set_all(32'h0);
    D_regDst = 5'd7; D_RF_wrd = 1'b1;
    step();
    set_all(32'h0);
    A_w = 32'h1234; A_regDst_i = 5'd7; A_RF_wrd_i = 1'b1;
    step();
    set_all(32'h0);
    C_w_i = 32'h1234; C_regDst_i = 5'd7; C_RF_wrd_i = 1'b1; C_dataD = 32'hCAFE_0001;
    step();

    set_all(32'h0);
    D_BranchOffset = 32'hFFFF_8000; D_DC_rd_wr = 2'b11;
    step();

    foreach (pats[i]) begin
      set_all(pats[i]);
      step();
    end

`ifdef PIPE_STALL_EN
    set_all(32'h1111_1111);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_all(32'hFFFF_FFFF - 32'(i * 32'h0101_0101));
      step();
    end
    stall = 1'b0;
    set_all(32'h2468_ACE0);
    step();
    stall = 1'b1;
    set_all(32'hFFFF_FFFF);
    rst_n = 1'b0;
    step();
    stall = 1'b0;
    rst_n = 1'b1;
    step();
`endif

    // Reset in the middle of traffic discards everything in flight
    set_all(32'hFFFF_FFFF);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_all(32'h0000_7FFF);
    step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
